pipeline_hazard_ctrl: RTL and testbench

Hazard and stall scheduler for the BEAN-2 five-stage RV32I pipeline. It generates the `stall_*` and `flush_*` strobes that sequence the fetch/decode registers and the E/M/WB control and data registers. It tracks destination registers for the E, M and WB stages in its own shadow scoreboard and selects E-stage operand forwarding. It also times out hung data-memory accesses.

---
 rtl/pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall scheduler for the BEAN-2 five-stage pipeline: shadow E/M/WB
// scoreboard, load-use and redirect sequencing, E-operand forwarding, data-memory wait timeout.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rd_D,
    input  logic [1:0] reg_RD_D,
    input  logic       reg_WE_D,
    input  logic       load_D,
    input  logic [1:0] pc_SEL_M,
    input  logic       dmem_req_M,
    input  logic       dmem_ready,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       stall_WB,
    output logic       flush_D,
    output logic       flush_E,
    output logic       flush_M,
    output logic       flush_WB,
    output logic [1:0] fwd_A_SEL,
    output logic [1:0] fwd_B_SEL,
    output logic       mem_timeout
);

    typedef enum logic {ST_IDLE, ST_WAIT} wait_state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    wait_state_t      r_state;
    wait_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] w_wcnt_nxt;
    logic             r_mem_timeout;

    logic       r_v_E, r_v_M, r_v_WB;
    logic [4:0] r_rd_E, r_rd_M, r_rd_WB;
    logic       r_ld_E;
    logic [4:0] r_rs1_E, r_rs2_E;

    logic w_miss;
    logic w_abandon;
    logic w_mem_wait;
    logic w_redirect;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;

    assign w_miss = dmem_req_M && !dmem_ready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_abandon   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_state_nxt = ST_WAIT;
                    w_wcnt_nxt  = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!w_miss) begin
                    w_state_nxt = ST_IDLE;
                    w_wcnt_nxt  = '0;
                end else if (r_wcnt == TIMEOUT_CNT) begin
                    // Give up on the access: release the pipeline and flag the error.
                    w_abandon   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_wcnt_nxt = r_wcnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    assign w_mem_wait = w_miss && !w_abandon;
    assign w_redirect = (pc_SEL_M != 2'b00) && !w_mem_wait;
    assign w_rs1_hit  = reg_RD_D[0] && (rs1_D == r_rd_E);
    assign w_rs2_hit  = reg_RD_D[1] && (rs2_D == r_rd_E);
    assign w_load_use = r_v_E && r_ld_E && (w_rs1_hit || w_rs2_hit) && !w_mem_wait && !w_redirect;

    // Strobes are forced idle while reset is held, whatever the inputs show.
    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        stall_E  = 1'b0;
        stall_M  = 1'b0;
        flush_D  = 1'b0;
        flush_E  = 1'b0;
        flush_M  = 1'b0;
        flush_WB = 1'b0;
        if (reset) begin
            if (w_mem_wait) begin
                stall_F  = 1'b1;
                stall_D  = 1'b1;
                stall_E  = 1'b1;
                stall_M  = 1'b1;
                flush_WB = 1'b1;
            end else if (w_redirect) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
                flush_M = 1'b1;
            end else if (w_load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    assign stall_WB = 1'b0;

    always_comb begin
        fwd_A_SEL = 2'b00;
        fwd_B_SEL = 2'b00;
        if (reset) begin
            if (r_v_M && (r_rd_M == r_rs1_E))        fwd_A_SEL = 2'b01;
            else if (r_v_WB && (r_rd_WB == r_rs1_E)) fwd_A_SEL = 2'b10;
            if (r_v_M && (r_rd_M == r_rs2_E))        fwd_B_SEL = 2'b01;
            else if (r_v_WB && (r_rd_WB == r_rs2_E)) fwd_B_SEL = 2'b10;
        end
    end

    assign mem_timeout = r_mem_timeout;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_wcnt        <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_abandon) r_mem_timeout <= 1'b1;
        end
    end

    // Shadow of the E/M/WB stage registers, driven by the same strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v_E   <= 1'b0;
            r_v_M   <= 1'b0;
            r_v_WB  <= 1'b0;
            r_rd_E  <= '0;
            r_rd_M  <= '0;
            r_rd_WB <= '0;
            r_ld_E  <= 1'b0;
            r_rs1_E <= '0;
            r_rs2_E <= '0;
        end else begin
            if (flush_E) begin
                r_v_E <= 1'b0;
            end else if (!stall_E) begin
                r_v_E   <= reg_WE_D && (rd_D != 5'd0);
                r_rd_E  <= rd_D;
                r_ld_E  <= load_D;
                r_rs1_E <= rs1_D;
                r_rs2_E <= rs2_D;
            end

            if (flush_M) begin
                r_v_M <= 1'b0;
            end else if (!stall_M) begin
                r_v_M  <= r_v_E;
                r_rd_M <= r_rd_E;
            end

            if (flush_WB) begin
                r_v_WB <= 1'b0;
            end else if (!stall_WB) begin
                r_v_WB  <= r_v_M;
                r_rd_WB <= r_rd_M;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with hand-derived
// expectations, then randomized traffic against a stage-array pipeline model.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_D, rs2_D, rd_D;
    logic [1:0] reg_RD_D;
    logic       reg_WE_D, load_D;
    logic [1:0] pc_SEL_M;
    logic       dmem_req_M, dmem_ready;
    logic       stall_F, stall_D, stall_E, stall_M, stall_WB;
    logic       flush_D, flush_E, flush_M, flush_WB;
    logic [1:0] fwd_A_SEL, fwd_B_SEL;
    logic       mem_timeout;

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .reg_RD_D(reg_RD_D),
        .reg_WE_D(reg_WE_D), .load_D(load_D), .pc_SEL_M(pc_SEL_M),
        .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .stall_WB(stall_WB), .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
        .flush_WB(flush_WB), .fwd_A_SEL(fwd_A_SEL), .fwd_B_SEL(fwd_B_SEL),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pipeline model: index 0 = E, 1 = M, 2 = WB.
    logic       m_v  [3];
    logic [4:0] m_rd [3];
    logic       m_ld;
    logic [4:0] m_rs1, m_rs2;
    int         m_cnt;
    logic       m_to;

    logic       e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_fWB, e_ab, e_mw;
    logic [1:0] e_fa, e_fb;
    logic [13:0] exp_vec;
    logic [13:0] want;

    localparam logic [13:0] MEM_WAIT_VEC = {5'b11110, 4'b0001, 2'b00, 2'b00, 1'b0};
    localparam logic [13:0] REDIR_VEC    = {5'b00000, 4'b1110, 2'b00, 2'b00, 1'b0};

    function automatic logic [13:0] dut_vec();
        return {stall_F, stall_D, stall_E, stall_M, stall_WB,
                flush_D, flush_E, flush_M, flush_WB, fwd_A_SEL, fwd_B_SEL, mem_timeout};
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] r);
        if (m_v[1] && m_rd[1] == r) return 2'b01;
        if (m_v[2] && m_rd[2] == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i]  = 1'b0;
            m_rd[i] = 5'd0;
        end
        m_ld = 1'b0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_cnt = 0; m_to = 1'b0;
    endtask

    task automatic model_eval();
        logic miss, redir, hit, lu;
        miss  = dmem_req_M && !dmem_ready;
        e_ab  = miss && (m_cnt == TO);
        e_mw  = miss && !e_ab;
        redir = (pc_SEL_M != 2'b00) && !e_mw;
        hit   = m_v[0] && m_ld && ((reg_RD_D[0] && rs1_D == m_rd[0]) || (reg_RD_D[1] && rs2_D == m_rd[0]));
        lu    = hit && !e_mw && !redir;
        e_sF = e_mw || lu; e_sD = e_mw || lu; e_sE = e_mw; e_sM = e_mw; e_fWB = e_mw;
        e_fD = redir; e_fE = redir || lu; e_fM = redir;
        e_fa = fwd_of(m_rs1);
        e_fb = fwd_of(m_rs2);
        if (!reset) begin
            {e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_fWB, e_ab, e_mw} = '0;
            e_fa = 2'b00; e_fb = 2'b00;
        end
        exp_vec = {e_sF, e_sD, e_sE, e_sM, 1'b0, e_fD, e_fE, e_fM, e_fWB, e_fa, e_fb, m_to};
    endtask

    task automatic model_update();
        if (e_ab) m_to = 1'b1;
        m_cnt = e_mw ? m_cnt + 1 : 0;
        if (e_fWB) m_v[2] = 1'b0;
        else begin m_v[2] = m_v[1]; m_rd[2] = m_rd[1]; end
        if (e_fM) m_v[1] = 1'b0;
        else if (!e_sM) begin m_v[1] = m_v[0]; m_rd[1] = m_rd[0]; end
        if (e_fE) m_v[0] = 1'b0;
        else if (!e_sE) begin
            m_v[0] = reg_WE_D && (rd_D != 5'd0); m_rd[0] = rd_D; m_ld = load_D;
            m_rs1 = rs1_D; m_rs2 = rs2_D;
        end
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd, input int rr, input int we,
                         input int ld, input int pc, input int req, input int rdy);
        rs1_D = 5'(rs1); rs2_D = 5'(rs2); rd_D = 5'(rd); reg_RD_D = 2'(rr);
        reg_WE_D = 1'(we); load_D = 1'(ld); pc_SEL_M = 2'(pc);
        dmem_req_M = 1'(req); dmem_ready = 1'(rdy);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic flush_pipe();
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(5, 5, 5, 3, 1, 1, 3, 1, 0);
        #3;
        want = '0;
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL reset_hold got=%b want=%b", dut_vec(), want); end
        idle();
        model_reset();
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        settle();
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL reset_release got=%b want=%b", dut_vec(), want); end
    endtask

    task automatic test_load_use();
        flush_pipe();
        drive(2, 0, 5, 1, 1, 1, 0, 0, 0);          // lw x5
        settle(); tick();
        drive(5, 1, 6, 3, 1, 0, 0, 0, 0);          // add x6,x5,x1
        settle();
        want = {5'b11000, 4'b0100, 2'b00, 2'b00, 1'b0};
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL lu_stall got=%b want=%b", dut_vec(), want); end
        tick();
        settle();
        want = '0;
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL lu_one_cycle got=%b want=%b", dut_vec(), want); end
        tick();
        idle(); settle();
        want = {9'b0, 2'b10, 2'b00, 1'b0};
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL lu_fwd_wb got=%b want=%b", dut_vec(), want); end
        tick();
    endtask

    task automatic test_back_to_back();
        flush_pipe();
        drive(1, 0, 3, 1, 1, 0, 0, 0, 0);          // addi x3
        settle(); tick();
        drive(3, 3, 4, 3, 1, 0, 0, 0, 0);          // sub x4,x3,x3
        settle();
        want = '0;
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL b2b_nostall got=%b want=%b", dut_vec(), want); end
        tick();
        idle(); settle();
        want = {9'b0, 2'b01, 2'b01, 1'b0};
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL b2b_fwd_m got=%b want=%b", dut_vec(), want); end
        tick();
        flush_pipe();
        drive(1, 0, 3, 1, 1, 0, 0, 0, 0); settle(); tick();
        drive(2, 0, 9, 1, 1, 0, 0, 0, 0); settle(); tick();
        drive(3, 3, 4, 3, 1, 0, 0, 0, 0); settle(); tick();
        idle(); settle();
        want = {9'b0, 2'b10, 2'b10, 1'b0};
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL gap_fwd_wb got=%b want=%b", dut_vec(), want); end
        tick();
    endtask

    task automatic test_x0_double();
        flush_pipe();
        drive(1, 0, 0, 1, 1, 1, 0, 0, 0);          // lw x0
        settle(); tick();
        drive(0, 0, 8, 3, 1, 0, 0, 0, 0);          // add x8,x0,x0
        settle();
        want = '0;
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL x0_nostall got=%b want=%b", dut_vec(), want); end
        tick();
        idle(); settle();
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL x0_nofwd got=%b want=%b", dut_vec(), want); end
        tick();
        flush_pipe();
        drive(1, 0, 7, 1, 1, 0, 0, 0, 0); settle(); tick();
        drive(2, 0, 7, 1, 1, 0, 0, 0, 0); settle(); tick();
        drive(7, 2, 10, 3, 1, 0, 0, 0, 0); settle(); tick();
        idle(); settle();
        want = {9'b0, 2'b01, 2'b00, 1'b0};
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL double_match got=%b want=%b", dut_vec(), want); end
        tick();
    endtask

    task automatic test_redirect();
        flush_pipe();
        drive(0, 0, 1, 0, 1, 0, 0, 0, 0);          // jal x1
        settle(); tick();
        drive(1, 0, 12, 1, 1, 0, 0, 0, 0);         // reads x1
        settle(); tick();
        drive(3, 0, 13, 1, 1, 0, 3, 0, 0);         // jump now in M redirects
        settle();
        want = {5'b00000, 4'b1110, 2'b01, 2'b00, 1'b0};
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL redirect got=%b want=%b", dut_vec(), want); end
        tick();
        idle(); settle();
        want = {9'b0, 2'b10, 2'b00, 1'b0};
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL redirect_wb got=%b want=%b", dut_vec(), want); end
        tick();
        flush_pipe();
        drive(2, 0, 5, 1, 1, 1, 0, 0, 0); settle(); tick();
        drive(5, 0, 6, 1, 1, 0, 1, 0, 0);          // load-use coincident with redirect
        settle();
        total++;
        if (dut_vec() !== REDIR_VEC) begin bad++; $display("FAIL redir_over_lu got=%b want=%b", dut_vec(), REDIR_VEC); end
        tick();
    endtask

    task automatic test_mem_wait();
        flush_pipe();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 0, (c == 1) ? 3 : 0, 1, 0);
            settle();
            total++;
            if (dut_vec() !== MEM_WAIT_VEC) begin bad++; $display("FAIL mem_wait_c%0d got=%b want=%b", c, dut_vec(), MEM_WAIT_VEC); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 3, 1, 1);          // release with deferred redirect
        settle();
        total++;
        if (dut_vec() !== REDIR_VEC) begin bad++; $display("FAIL mem_release got=%b want=%b", dut_vec(), REDIR_VEC); end
        tick();
    endtask

    task automatic test_timeout();
        flush_pipe();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < TO; c++) begin
            settle();
            total++;
            if (dut_vec() !== MEM_WAIT_VEC) begin bad++; $display("FAIL to_wait_c%0d got=%b want=%b", c, dut_vec(), MEM_WAIT_VEC); end
            tick();
        end
        settle();
        want = '0;
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL to_release got=%b want=%b", dut_vec(), want); end
        tick();
        idle();
        want = {13'b0, 1'b1};
        for (int c = 0; c < 3; c++) begin
            settle();
            total++;
            if (dut_vec() !== want) begin bad++; $display("FAIL to_sticky_c%0d got=%b want=%b", c, dut_vec(), want); end
            tick();
        end
        reset = 1'b0;
        #1;
        model_reset();
        want = '0;
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL to_clear got=%b want=%b", dut_vec(), want); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        flush_pipe();
        drive(2, 0, 5, 1, 1, 1, 0, 0, 0);          // lw x5 into E
        settle(); tick();
        drive(5, 0, 6, 1, 1, 0, 0, 1, 0);
        for (int c = 0; c < 2; c++) begin
            settle();
            total++;
            if (dut_vec() !== MEM_WAIT_VEC) begin bad++; $display("FAIL mid_wait_c%0d got=%b want=%b", c, dut_vec(), MEM_WAIT_VEC); end
            tick();
        end
        reset = 1'b0;
        #1;
        want = '0;
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL mid_reset got=%b want=%b", dut_vec(), want); end
        model_reset();
        idle();
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        drive(5, 0, 6, 1, 1, 0, 0, 0, 0);          // old load's consumer
        settle();
        total++;
        if (dut_vec() !== want) begin bad++; $display("FAIL mid_no_stale got=%b want=%b", dut_vec(), want); end
        tick();
    endtask

    task automatic test_random();
        int ready_pct;
        flush_pipe();
        for (int c = 0; c < 3000; c++) begin
            ready_pct = ((c / 300) % 2 == 0) ? 70 : 8;
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0,
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  ($urandom_range(0, 99) < ready_pct) ? 1 : 0);
            settle();
            total++;
            if (dut_vec() !== exp_vec) begin bad++; $display("FAIL rand_c%0d got=%b want=%b", c, dut_vec(), exp_vec); end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_back_to_back();
        test_x0_double();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
